// File: rtl/wb_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wb_buffer
//   Write-back buffer between an image accelerator and a shared memory port.
//   Result words (4 packed pixels) are queued in a small FIFO and written to
//   memory starting at word address WORDS, one word per granted cycle.
//
//   Parameters
//     WIDTH, HEIGHT : image size in pixels (WIDTH a multiple of 4)
//     DEPTH         : FIFO entries (power of 2, >= 4)
//     THRESH        : occupancy at which a memory request is raised in RUN
//
//   Ports
//     clk, rst      : clock, asynchronous active-low reset
//     start         : pulse, begins a frame (accepted in IDLE / DONE)
//     we, di, full  : accelerator push strobe, data word, FIFO-full back-pressure
//     flush         : pulse, last word of the frame has been pushed
//     req, gnt      : memory port request / grant
//     mem_en, mem_we, mem_addr, mem_di : memory write port
//     done          : frame completely written
//     overflow      : sticky, a word arrived beyond the frame size
// -----------------------------------------------------------------------------
module wb_buffer #(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 288,
  parameter int DEPTH  = 8,
  parameter int THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] di,
  output logic        full,
  input  logic        flush,
  output logic        req,
  input  logic        gnt,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_di,
  output logic        done,
  output logic        overflow
);

  localparam int WORDS = WIDTH / 4 * HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
  localparam logic [15:0]   WORDS_C  = 16'(WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // FIFO storage: plain write-enabled RAM, no reset needed since the
  // pointers and count define which entries are valid.
  logic [31:0]   fifo_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [15:0]   wcnt_q,   wcnt_d;
  logic          overflow_q, overflow_d;

  logic push;
  logic pop;
  logic clear;
  logic at_limit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)          state_d = RUN;
      RUN:     if (flush)          state_d = DRAIN;
      DRAIN:   if (count_q == '0)  state_d = DONE;
      DONE:    if (start)          state_d = RUN;
      default:                     state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // Only registered occupancy drives req, so a word pushed this cycle can
  // never be popped before the following cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    req  = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     req  = (count_q >= THRESH_C);
      DRAIN:   req  = (count_q != '0);
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    full     = (count_q == DEPTH_C);
    // full is evaluated on the registered count, so a pop in the same cycle
    // never frees a slot for the concurrent push.
    push     = we && !full && (state_q == RUN);
    pop      = req && gnt;
    clear    = start && ((state_q == IDLE) || (state_q == DONE));
    at_limit = (wcnt_q == WORDS_C);
  end

  // Memory write port: words beyond the frame are popped but not written.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;
    if (pop && !at_limit) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = WORDS_C + wcnt_q;
      mem_di   = fifo_mem[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wcnt_d     = wcnt_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      wcnt_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (at_limit) begin
          overflow_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wcnt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wcnt_q     <= wcnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= di;
    end
  end

  assign overflow = overflow_q;

endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 352, image width in pixels (multiple of 4).
REQ-002 SHALL have parameter HEIGHT, default 288, image height in pixels.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, >=4).
REQ-004 SHALL have parameter THRESH, default 4, FIFO occupancy that triggers a memory request in RUN.
REQ-005 SHALL have derived constant WORDS = WIDTH/4*HEIGHT (25344 by default), which is also the result base address.
REQ-006 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port start  input  1  one-cycle pulse to begin a frame.
REQ-009 SHALL have port we  input  1  accelerator push strobe.
REQ-010 SHALL have port di  input  32  result word, 4 packed pixels.
REQ-011 SHALL have port full  output  1  FIFO full; the accelerator must hold its push.
REQ-012 SHALL have port flush  input  1  one-cycle pulse: last word of the frame has been pushed.
REQ-013 SHALL have port req  output  1  request for the shared memory port.
REQ-014 SHALL have port gnt  input  1  memory port granted this cycle (from the cache arbiter).
REQ-015 SHALL have ports mem_en and mem_we, each  output  1  memory enable and write enable.
REQ-016 SHALL have port mem_addr  output  16  memory word address.
REQ-017 SHALL have port mem_di  output  32  memory write data.
REQ-018 SHALL have port done  output  1  frame fully written to memory.
REQ-019 SHALL have port overflow  output  1  sticky flag: a write exceeded the frame size.

Function
REQ-020 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-021 SHALL make the following transitions: IDLE--start-->RUN; RUN--flush-->DRAIN; DRAIN--FIFO empty-->DONE; DONE--start-->RUN.
REQ-022 SHALL, on start in IDLE or DONE, clear the FIFO, the address counter and overflow, and deassert done in the next cycle.
REQ-023 SHALL ignore start while in RUN or DRAIN.
REQ-024 SHALL accept a push only when we=1, full=0 and state is RUN; pushes in any other state or while full SHALL be dropped.
REQ-025 SHALL drive full=1 exactly when count==DEPTH; a pop in the same cycle SHALL NOT admit a push (no bypass).
REQ-026 SHALL drive req=1 in RUN when count>=THRESH, and in DRAIN when count>0; otherwise req=0.
REQ-027 SHALL, when req=1 and gnt=1, in the same cycle drive mem_en=mem_we=1, mem_di=FIFO head and mem_addr=WORDS+wcnt, pop the head and increment wcnt.
REQ-028 SHALL drive mem_en=mem_we=0 and mem_addr/mem_di=0 whenever no write is issued.
REQ-029 SHALL make a pushed word eligible for writing one cycle after the push, never in the push cycle.
REQ-030 SHALL, on a simultaneous push and pop, leave count unchanged and preserve FIFO order.
REQ-031 SHALL, when wcnt==WORDS, pop without writing (mem_en=0), set overflow and hold wcnt.
REQ-032 SHALL make the 16-bit address wrap impossible by the WORDS limit: the maximum address is 2*WORDS-1.
REQ-033 SHALL, on flush in the same cycle as a push, accept the push before entering DRAIN.
REQ-034 SHALL hold done=1 throughout DONE.

Reset
REQ-035 SHALL, on rst=0, immediately force state IDLE, count=0, FIFO pointers=0, wcnt=0, and full, req, mem_en, mem_we, done, overflow=0, mem_addr=0, mem_di=0.
REQ-036 SHALL discard FIFO contents when reset is asserted mid-frame and write no further words until the next start.

Verification
REQ-037 SHALL pass this scenario: reset, start, push 0x11111111..0x44444444 with gnt=1 -> req rises the cycle after the 4th push; writes go to 25344..25347 in order.
REQ-038 SHALL pass this scenario: gnt=0, push 9 words -> full=1 after the 8th push, the 9th is dropped; then gnt=1 with flush -> exactly 8 writes, then done=1.
REQ-039 SHALL pass this scenario: continuous push with gnt=1 and count at THRESH -> count stays constant and the data order is preserved.
REQ-040 SHALL pass this scenario: push 2 words, flush, gnt=1 -> 2 writes at 25344 and 25345 below the threshold, then DONE.
REQ-041 SHALL pass this scenario: with WIDTH=8 and HEIGHT=2 (WORDS=4), push 5 words -> 4 writes at 4..7; the 5th is popped unwritten and overflow=1.
REQ-042 SHALL pass this scenario: rst=0 mid-frame with 3 words queued -> all outputs are 0 immediately; after release and start, the next write goes to address WORDS.
